// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/ack handshake
// and hands one instruction at a time to decode, honouring redirects and kills.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        if_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   typedef enum logic [1:0] {IDLE, REQ, OUT, FAULT} state_t;

   state_t      state;
   logic        kill;
   logic [31:0] fetch_pc;
   logic [31:0] pending_pc;
   logic        xfer;
   logic        bad_redir;

   // fetch_pc is itself a register, so the address output stays registered
   assign imem_addr = fetch_pc;
   assign xfer      = if_valid & if_ready;
   assign bad_redir = redirect & redirect_pc[1];

   // NOTE: every state and output bit is updated with <= in one clocked block,
   // so all outputs are flops and there is no input-to-output combinational path.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         imem_req     <= 1'b0;
         fetch_pc     <= RESET_PC;
         if_valid     <= 1'b0;
         if_pc        <= RESET_PC;
         if_inst      <= NOP_INST;
         misalign_err <= 1'b0;
         kill         <= 1'b0;
         pending_pc   <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (bad_redir) begin
                  misalign_err <= 1'b1;
                  state        <= FAULT;
               end else begin
                  if (redirect) fetch_pc <= redirect_pc;
                  state <= REQ;
               end
            end

            REQ: begin
               if (bad_redir) begin
                  misalign_err <= 1'b1;
                  imem_req     <= 1'b0;
                  kill         <= 1'b0;
                  state        <= FAULT;
               end else if (!imem_req) begin
                  // issue cycle: nothing outstanding, so a redirect just retargets
                  if (redirect) fetch_pc <= redirect_pc;
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  if (redirect) begin
                     fetch_pc <= redirect_pc;
                     kill     <= 1'b0;
                  end else if (kill) begin
                     fetch_pc <= pending_pc;
                     kill     <= 1'b0;
                     imem_req <= 1'b0;
                  end else begin
                     if_inst  <= imem_rdata;
                     if_pc    <= fetch_pc;
                     if_valid <= 1'b1;
                     imem_req <= 1'b0;
                     state    <= OUT;
                  end
               end else if (redirect) begin
                  kill       <= 1'b1;
                  pending_pc <= redirect_pc;
               end
            end

            OUT: begin
               if (bad_redir) begin
                  misalign_err <= 1'b1;
                  if_valid     <= 1'b0;
                  state        <= FAULT;
               end else if (redirect || xfer) begin
                  if_valid <= 1'b0;
                  imem_req <= 1'b1;
                  fetch_pc <= redirect ? redirect_pc : if_pc + 32'd4;
                  state    <= REQ;
               end
            end

            FAULT: begin
               state <= FAULT;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected {pc, inst} pairs,
// a forked monitor pops and compares on every decode transfer.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        misalign_err;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   lat = 0;
   logic spam = 1'b0;
   exp_t exp_q[$];
   int   xfer_cyc[$];

   fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .if_ready     (if_ready),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, inst: mem_word(pc)});
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_empty(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (exp_q.size() == 0) break;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (if_valid) break;
      end
      check(name, 32'(if_valid), 1);
   endtask

   // memory responder: ack after lat wait cycles, or garbage acks while spam=1
   task automatic mem_model();
      int cnt = 0;
      forever begin
         @(negedge clk);
         if (spam) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end else if (imem_req) begin
            if (cnt >= lat) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
               cnt        = 0;
            end else begin
               imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            cnt      = 0;
         end
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && if_valid && if_ready) begin
            xfer_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL xfer_unexpected: got pc=%h inst=%h, required no transfer", if_pc, if_inst);
            end else begin
               e = exp_q.pop_front();
               if (if_pc !== e.pc || if_inst !== e.inst) begin
                  miscompares++;
                  $display("FAIL xfer: got pc=%h inst=%h, required pc=%h inst=%h",
                           if_pc, if_inst, e.pc, e.inst);
               end
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1;
      fork
         mem_model();
         monitor();
      join_none

      // reset values and sequential fetch from RESET_PC
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #1;
      check("rst_req", 32'(imem_req), 0);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_valid", 32'(if_valid), 0);
      check("rst_pc", if_pc, RST_PC);
      check("rst_inst", if_inst, NOP);
      check("rst_err", 32'(misalign_err), 0);
      push(32'h100); push(32'h104); push(32'h108);
      if_ready = 1'b1;
      lat = 0;
      step(); step();
      rstn = 1'b1;
      step();
      check("idle_no_req", 32'(imem_req), 0);
      step();
      check("first_req", 32'(imem_req), 1);
      check("first_addr", imem_addr, 32'h100);
      wait_empty("seq_drain", 30);
      if_ready = 1'b0;
      check("seq_xfers", xfer_cyc.size(), 3);
      if (xfer_cyc.size() >= 3) begin
         d0 = xfer_cyc[1] - xfer_cyc[0];
         d1 = xfer_cyc[2] - xfer_cyc[1];
         check("seq_spacing_a", d0, 2);
         check("seq_spacing_b", d1, 2);
      end

      // backpressure: output held, no new request
      wait_valid("bp_valid_up", 10);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(if_valid), 1);
         check("bp_pc", if_pc, 32'h10C);
         check("bp_inst", if_inst, mem_word(32'h10C));
         check("bp_no_req", 32'(imem_req), 0);
         step();
      end
      push(32'h10C);
      if_ready = 1'b1;
      wait_empty("bp_drain", 10);
      if_ready = 1'b0;
      check("bp_next_req", 32'(imem_req), 1);
      check("bp_next_addr", imem_addr, 32'h110);

      // two redirects while a 3-wait fetch is outstanding: last one wins
      push(32'h110);
      lat = 3;
      if_ready = 1'b1;
      wait_empty("wait_pre_drain", 20);
      if_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      check("kill_addr_stable", imem_addr, 32'h114);
      push(32'h300);
      if_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (imem_req && imem_addr != 32'h114) break;
         step();
      end
      check("kill_new_addr", imem_addr, 32'h300);
      wait_empty("kill_drain", 20);
      if_ready = 1'b0;

      // redirect coincident with a transfer in OUT
      redirect = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      lat = 1;
      wait_valid("co_valid_up", 30);
      check("co_pc", if_pc, 32'h40);
      push(32'h40);
      if_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect = 1'b0;
      if_ready = 1'b0;
      check("co_addr", imem_addr, 32'h80);
      check("co_req", 32'(imem_req), 1);
      check("co_valid_drop", 32'(if_valid), 0);
      check("co_consumed", exp_q.size(), 0);
      push(32'h80);
      if_ready = 1'b1;
      wait_empty("co_drain", 20);
      if_ready = 1'b0;

      // PC wrap from the top of the address space
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      push(32'hFFFF_FFFC);
      push(32'h0000_0000);
      if_ready = 1'b1;
      wait_empty("wrap_drain", 40);
      if_ready = 1'b0;

      // misaligned target abandons the outstanding fetch and freezes
      redirect = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
      check("mis_err", 32'(misalign_err), 1);
      check("mis_req", 32'(imem_req), 0);
      check("mis_valid", 32'(if_valid), 0);
      if_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h500;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("fault_req", 32'(imem_req), 0);
         check("fault_valid", 32'(if_valid), 0);
         check("fault_err", 32'(misalign_err), 1);
         check("fault_addr", imem_addr, 32'h4);
         step();
      end
      check("fault_pc", if_pc, 32'h0);
      if_ready = 1'b0;

      // async reset, then reset again mid-request with ack pulses during reset
      rstn = 1'b0;
      #1;
      check("rst2_err", 32'(misalign_err), 0);
      check("rst2_addr", imem_addr, RST_PC);
      check("rst2_inst", if_inst, NOP);
      step();
      rstn = 1'b1;
      lat = 3;
      for (int i = 0; i < 10; i++) begin
         step();
         if (imem_req) break;
      end
      check("mid_req_up", 32'(imem_req), 1);
      #1 rstn = 1'b0;
      #1;
      check("mid_req_drop", 32'(imem_req), 0);
      check("mid_valid", 32'(if_valid), 0);
      spam = 1'b1;
      step(); step();
      check("spam_req", 32'(imem_req), 0);
      check("spam_valid", 32'(if_valid), 0);
      spam = 1'b0;
      @(negedge clk);
      step();
      rstn = 1'b1;
      lat = 0;
      push(32'h100);
      if_ready = 1'b1;
      wait_empty("restart_drain", 20);
      if_ready = 1'b0;
      step(); step();

      check("final_queue", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
